// File: rtl/booth_sequencer.sv
// Radix-2 Booth multiplier sequencer: drives the external M-register load strobe,
// iterates add/subtract/shift on A/Q/Q-1 and presents the signed product with Start/Done.
module booth_sequencer #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           Reset,
  input  logic           Start,
  input  logic [N-1:0]   Q_in,
  input  logic [N-1:0]   salidaM,
  output logic           CargaM,
  output logic           ResetM,
  output logic           Busy,
  output logic           Done,
  output logic [2*N-1:0] Producto
);

  // state | meaning
  // IDLE  | waiting for Start
  // LOAD  | strobe CargaM, capture Q_in, clear A/Q-1, arm counter
  // ITER  | one Booth step per cycle, N cycles
  // DONE  | one-cycle Done pulse, Producto valid

  typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;

  localparam int CW = $clog2(N + 1);

  state_t         state, state_next;
  logic [N:0]     a_reg, a_sum, a_next, mx;
  logic [N-1:0]   q_reg, q_next;
  logic           q_m1, q_m1_next;
  logic [CW-1:0]  count;

  assign ResetM = Reset;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    CargaM     = 1'b0;
    Busy       = 1'b0;
    Done       = 1'b0;
    case (state)
      IDLE: if (Start) state_next = LOAD;
      LOAD: begin
        CargaM     = 1'b1;
        Busy       = 1'b1;
        state_next = ITER;
      end
      ITER: begin
        Busy = 1'b1;
        if (count == CW'(1)) state_next = DONE;
      end
      DONE: begin
        Done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A is one bit wider than the operand so A - (-2^(N-1)) cannot overflow.
  always_comb begin
    mx = {salidaM[N-1], salidaM};
    case ({q_reg[0], q_m1})
      2'b01:   a_sum = a_reg + mx;
      2'b10:   a_sum = a_reg - mx;
      default: a_sum = a_reg;
    endcase
    {a_next, q_next, q_m1_next} = {a_sum[N], a_sum, q_reg};
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      a_reg    <= '0;
      q_reg    <= '0;
      q_m1     <= 1'b0;
      count    <= '0;
      Producto <= '0;
    end else begin
      case (state)
        LOAD: begin
          a_reg <= '0;
          q_reg <= Q_in;
          q_m1  <= 1'b0;
          count <= CW'(N);
        end
        ITER: begin
          a_reg <= a_next;
          q_reg <= q_next;
          q_m1  <= q_m1_next;
          count <= count - CW'(1);
          if (count == CW'(1)) Producto <= {a_next[N-1:0], q_next};
        end
        default: ;
      endcase
    end
  end

endmodule
